// File: rtl/md_scheduler.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO pair. Results are computed at
// issue, held in pending registers, and committed to HI/LO once the latency has elapsed.
module md_scheduler #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MDop,
  input  logic [1:0]  HILO_Rop,
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  input  logic        Req,
  output logic        Busy,
  output logic        done,
  output logic [31:0] HILO_output,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;
  logic             done_q, done_d;

  // The counter is the whole FSM: non-zero means an operation is in flight.
  assign state = (cnt_q != '0) ? RUN : IDLE;

  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{num1[31]}}, num1} * {{32{num2[31]}}, num2};
  assign prod_u = {32'd0, num1} * {32'd0, num2};

  // One unsigned divider serves both div and divu; signed div works on magnitudes.
  logic        div_signed, div_by_zero, quo_neg;
  logic [31:0] abs1, abs2, dvd, dvs, uquo, urem, quo_res, rem_res;

  always_comb begin
    div_signed  = (MDop == OP_DIV);
    div_by_zero = (num2 == 32'd0);
    quo_neg     = num1[31] ^ num2[31];
    abs1        = num1[31] ? (32'd0 - num1) : num1;
    abs2        = num2[31] ? (32'd0 - num2) : num2;
    dvd         = div_signed ? abs1 : num1;
    dvs         = div_by_zero ? 32'd1 : (div_signed ? abs2 : num2);
    uquo        = dvd / dvs;
    urem        = dvd % dvs;
    quo_res     = uquo;
    rem_res     = urem;
    if (div_signed) begin
      quo_res = quo_neg  ? (32'd0 - uquo) : uquo;
      rem_res = num1[31] ? (32'd0 - urem) : urem;
    end
  end

  // Next-state: issue from IDLE, countdown and commit in RUN.
  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    done_d    = 1'b0;
    case (state)
      IDLE: begin
        if (!Req) begin
          case (MDop)
            OP_MULT: begin
              pend_hi_d = prod_s[63:32];
              pend_lo_d = prod_s[31:0];
              pend_wr_d = 1'b1;
              cnt_d     = CNT_W'(MULT_LAT);
            end
            OP_MULTU: begin
              pend_hi_d = prod_u[63:32];
              pend_lo_d = prod_u[31:0];
              pend_wr_d = 1'b1;
              cnt_d     = CNT_W'(MULT_LAT);
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_d = rem_res;
              pend_lo_d = quo_res;
              pend_wr_d = !div_by_zero;
              cnt_d     = CNT_W'(DIV_LAT);
            end
            OP_MTHI: hi_d = num1;
            OP_MTLO: lo_d = num1;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Req is deliberately ignored here: the issuing instruction already retired.
        if (cnt_q == CNT_W'(1)) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          done_d = 1'b1;
        end
        cnt_d = cnt_q - CNT_W'(1);
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      done_q    <= done_d;
    end
  end

  assign Busy = (state == RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    case (HILO_Rop)
      2'b01:   HILO_output = hi_q;
      2'b10:   HILO_output = lo_q;
      default: HILO_output = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_md_scheduler.sv
// Bench for md_scheduler: directed scenarios plus random traffic against a
// timestamp-based reference model of HI/LO and operation completion.
module tb_md_scheduler;
  localparam int unsigned MULT_LAT = 5;
  localparam int unsigned DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  MDop;
  logic [1:0]  HILO_Rop;
  logic [31:0] num1, num2;
  logic        Req;
  logic        Busy, done;
  logic [31:0] HILO_output, hi, lo;

  md_scheduler #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .MDop(MDop), .HILO_Rop(HILO_Rop), .num1(num1), .num2(num2),
    .Req(Req), .Busy(Busy), .done(done), .HILO_output(HILO_output), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: absolute cycle index, and the cycle at which the pending result lands.
  longint      cyc = 0;
  longint      commit_at = -1;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          p_wr = 1'b0;

  task automatic model_issue(input longint now);
    longint sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(num1));
    sb = longint'($signed(num2));
    ua = {32'd0, num1};
    ub = {32'd0, num2};
    p_wr = 1'b1;
    case (MDop)
      3'd1: begin sp = sa * sb; p_hi = sp[63:32]; p_lo = sp[31:0]; commit_at = now + longint'(MULT_LAT); end
      3'd2: begin up = ua * ub; p_hi = up[63:32]; p_lo = up[31:0]; commit_at = now + longint'(MULT_LAT); end
      3'd3: begin
        if (num2 == 32'd0) p_wr = 1'b0;
        else begin sp = sa / sb; p_lo = sp[31:0]; sp = sa % sb; p_hi = sp[31:0]; end
        commit_at = now + longint'(DIV_LAT);
      end
      default: begin
        if (num2 == 32'd0) p_wr = 1'b0;
        else begin up = ua / ub; p_lo = up[31:0]; up = ua % ub; p_hi = up[31:0]; end
        commit_at = now + longint'(DIV_LAT);
      end
    endcase
  endtask

  task automatic tick();
    longint c;
    bit busy_old;
    @(posedge clk);
    c = cyc;
    busy_old = (commit_at > c);
    cyc = c + 1;
    if (reset) begin
      m_hi = '0; m_lo = '0; commit_at = -1;
    end else begin
      if (busy_old && commit_at == c + 1 && p_wr) begin m_hi = p_hi; m_lo = p_lo; end
      if (!busy_old && !Req) begin
        if (MDop >= 3'd1 && MDop <= 3'd4) model_issue(c + 1);
        else if (MDop == 3'd5) m_hi = num1;
        else if (MDop == 3'd6) m_lo = num1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_checks++;
    if ({Busy, done, hi, lo} !== {1'b0, 1'b0, 32'd0, 32'd0}) begin
      n_fail++; $display("FAIL reset_state got busy=%b done=%b hi=%h lo=%h exp all zero", Busy, done, hi, lo);
    end
    HILO_Rop = 2'b01;
    #1;
    n_checks++;
    if (HILO_output !== 32'd0) begin n_fail++; $display("FAIL reset_read got=%h exp=0", HILO_output); end
    HILO_Rop = 2'b00;
  endtask

  task automatic test_mult();
    int n = 0;
    MDop = 3'd1; num1 = 32'hFFFFFFFD; num2 = 32'd5;
    tick();
    MDop = 3'd0;
    while (Busy === 1'b1 && done === 1'b0 && n < 40) begin n++; tick(); end
    n_checks++;
    if (n !== 5) begin n_fail++; $display("FAIL mult_busy_cycles got=%0d exp=5", n); end
    n_checks++;
    if ({done, hi, lo} !== {1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1}) begin
      n_fail++; $display("FAIL mult_result got done=%b hi=%h lo=%h exp 1 ffffffff fffffff1", done, hi, lo);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_div();
    int n = 0;
    MDop = 3'd4; num1 = 32'd7; num2 = 32'd2;
    tick();
    MDop = 3'd0;
    while (Busy === 1'b1 && n < 40) begin n++; tick(); end
    n_checks++;
    if ({n, done, hi, lo} !== {32'd10, 1'b1, 32'd1, 32'd3}) begin
      n_fail++; $display("FAIL divu_7_2 got n=%0d done=%b hi=%h lo=%h exp 10 1 1 3", n, done, hi, lo);
    end
    MDop = 3'd3; num1 = 32'hFFFFFFF9; num2 = 32'd2;
    tick();
    MDop = 3'd0;
    n = 0;
    while (Busy === 1'b1 && n < 40) begin n++; tick(); end
    n_checks++;
    if ({n, hi, lo} !== {32'd10, 32'hFFFFFFFF, 32'hFFFFFFFD}) begin
      n_fail++; $display("FAIL div_neg7_2 got n=%0d hi=%h lo=%h exp 10 ffffffff fffffffd", n, hi, lo);
    end
  endtask

  task automatic test_req();
    int n = 0;
    logic [31:0] old_hi, old_lo;
    old_hi = hi; old_lo = lo;
    MDop = 3'd1; num1 = 32'd6; num2 = 32'd7; Req = 1'b1;
    tick();
    Req = 1'b0;
    n_checks++;
    if ({Busy, hi, lo} !== {1'b0, old_hi, old_lo}) begin
      n_fail++; $display("FAIL req_cancel got busy=%b hi=%h lo=%h exp 0 %h %h", Busy, hi, lo, old_hi, old_lo);
    end
    tick();
    MDop = 3'd0;
    while (Busy === 1'b1 && n < 40) begin n++; Req = (n == 2); tick(); end
    Req = 1'b0;
    n_checks++;
    if ({n, hi, lo} !== {32'd5, 32'd0, 32'd42}) begin
      n_fail++; $display("FAIL req_midrun got n=%0d hi=%h lo=%h exp 5 0 2a", n, hi, lo);
    end
  endtask

  task automatic test_mthi();
    int n = 0;
    MDop = 3'd5; num1 = 32'h12345678;
    tick();
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy got=%b exp=0", Busy); end
    MDop = 3'd6; num1 = 32'hCAFEBABE;
    tick();
    MDop = 3'd0;
    n_checks++;
    if ({Busy, done} !== 2'b00) begin n_fail++; $display("FAIL mtlo_busy got=%b%b exp=00", Busy, done); end
    HILO_Rop = 2'b01; #1;
    n_checks++;
    if (HILO_output !== 32'h12345678) begin n_fail++; $display("FAIL read_hi got=%h exp=12345678", HILO_output); end
    HILO_Rop = 2'b10; #1;
    n_checks++;
    if (HILO_output !== 32'hCAFEBABE) begin n_fail++; $display("FAIL read_lo got=%h exp=cafebabe", HILO_output); end
    HILO_Rop = 2'b11; #1;
    n_checks++;
    if (HILO_output !== 32'd0) begin n_fail++; $display("FAIL read_none got=%h exp=0", HILO_output); end
    HILO_Rop = 2'b00;
    MDop = 3'd1; num1 = 32'd2; num2 = 32'd3;
    tick();
    MDop = 3'd5; num1 = 32'hDEADBEEF;
    tick();
    MDop = 3'd0;
    n_checks++;
    if ({Busy, hi} !== {1'b1, 32'h12345678}) begin
      n_fail++; $display("FAIL mthi_in_run got busy=%b hi=%h exp 1 12345678", Busy, hi);
    end
    while (Busy === 1'b1 && n < 40) begin n++; tick(); end
    n_checks++;
    if ({n, hi, lo} !== {32'd4, 32'd0, 32'd6}) begin
      n_fail++; $display("FAIL mult_after_mthi got n=%0d hi=%h lo=%h exp 4 0 6", n, hi, lo);
    end
  endtask

  task automatic test_div_edge();
    int n = 0;
    MDop = 3'd5; num1 = 32'hA5A5A5A5; tick();
    MDop = 3'd6; tick();
    MDop = 3'd3; num1 = 32'd123; num2 = 32'd0; tick();
    MDop = 3'd0;
    while (Busy === 1'b1 && n < 40) begin n++; tick(); end
    n_checks++;
    if ({n, done, hi, lo} !== {32'd10, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5}) begin
      n_fail++; $display("FAIL div_by_zero got n=%0d done=%b hi=%h lo=%h exp 10 1 a5a5a5a5 a5a5a5a5", n, done, hi, lo);
    end
    MDop = 3'd3; num1 = 32'h80000000; num2 = 32'hFFFFFFFF; tick();
    MDop = 3'd0;
    n = 0;
    while (Busy === 1'b1 && n < 40) begin n++; tick(); end
    n_checks++;
    if ({hi, lo} !== {32'd0, 32'h80000000}) begin
      n_fail++; $display("FAIL div_overflow got hi=%h lo=%h exp 0 80000000", hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    bit seen_done = 1'b0;
    MDop = 3'd3; num1 = 32'd100; num2 = 32'd7; tick();
    MDop = 3'd0;
    tick(); tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++;
    if ({Busy, done, hi, lo} !== {1'b0, 1'b0, 32'd0, 32'd0}) begin
      n_fail++; $display("FAIL reset_mid got busy=%b done=%b hi=%h lo=%h exp all zero", Busy, done, hi, lo);
    end
    for (int i = 0; i < 12; i++) begin tick(); if (done === 1'b1) seen_done = 1'b1; end
    n_checks++;
    if (seen_done !== 1'b0) begin n_fail++; $display("FAIL reset_mid_done got=1 exp=0"); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    MDop = 3'd1; num1 = 32'd3; num2 = 32'd4; tick();
    MDop = 3'd0;
    while (done !== 1'b1 && n < 40) begin n++; tick(); end
    n_checks++;
    if ({done, lo} !== {1'b1, 32'd12}) begin n_fail++; $display("FAIL b2b_first got done=%b lo=%h exp 1 c", done, lo); end
    MDop = 3'd1; num1 = 32'd5; num2 = 32'd6; tick();
    MDop = 3'd0;
    n_checks++;
    if ({Busy, lo} !== {1'b1, 32'd12}) begin n_fail++; $display("FAIL b2b_accept got busy=%b lo=%h exp 1 c", Busy, lo); end
    n = 0;
    while (Busy === 1'b1 && n < 40) begin n++; tick(); end
    n_checks++;
    if ({n, lo} !== {32'd5, 32'd30}) begin n_fail++; $display("FAIL b2b_second got n=%0d lo=%h exp 5 1e", n, lo); end
  endtask

  task automatic test_random();
    logic [31:0] e_out;
    for (int i = 0; i < 1500; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      MDop     = 3'($urandom_range(0, 7));
      Req      = ($urandom_range(0, 7) == 0);
      HILO_Rop = 2'($urandom_range(0, 3));
      num1     = $urandom();
      num2     = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom();
      if ($urandom_range(0, 15) == 0) begin num1 = 32'h80000000; num2 = 32'hFFFFFFFF; end
      tick();
      e_out = (HILO_Rop == 2'b01) ? m_hi : (HILO_Rop == 2'b10) ? m_lo : 32'd0;
      n_checks++;
      if ({Busy, done} !== {commit_at > cyc, commit_at == cyc}) begin
        n_fail++; $display("FAIL rnd_ctrl cyc=%0d got busy=%b done=%b exp %b %b", cyc, Busy, done, commit_at > cyc, commit_at == cyc);
      end
      n_checks++;
      if ({hi, lo, HILO_output} !== {m_hi, m_lo, e_out}) begin
        n_fail++; $display("FAIL rnd_data cyc=%0d got hi=%h lo=%h out=%h exp %h %h %h", cyc, hi, lo, HILO_output, m_hi, m_lo, e_out);
      end
    end
    reset = 1'b0; MDop = 3'd0; Req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; MDop = 3'd0; HILO_Rop = 2'b00; num1 = '0; num2 = '0; Req = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_req();
    test_mthi();
    test_div_edge();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
